mips_lite_mc_ctrl: RTL and testbench

Multi-cycle sequencing controller for the MIPS_Lite 16-bit datapath. It fetches each instruction through a req/ready handshake and holds it in an instruction register (IR) that drives the Instruc_decode block. It then steps the datapath through EXEC, MEM and WB, gating the decoder's write enables so that register-file and data-memory writes happen only in their own state. It also owns the PC, halt detection and a retired-instruction counter.

---
 rtl/mips_lite_mc_ctrl_if.sv | 22 ++
 rtl/mips_lite_mc_ctrl.sv | 116 +++++++++++
 tb/tb_mips_lite_mc_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_lite_mc_ctrl_if.sv
// Instruction- and data-memory handshake bundle between the sequencer and its memories.
interface mips_lite_mc_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [15:0]       imem_rdata;
  logic              dmem_req;
  logic              dmem_we;
  logic              dmem_ready;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we,
    input  imem_ready, imem_rdata, dmem_ready
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we,
    output imem_ready, imem_rdata, dmem_ready
  );
endinterface

// File: rtl/mips_lite_mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS_Lite datapath; owns PC, IR,
// halt detection and a saturating retired-instruction counter.
module mips_lite_mc_ctrl #(
  parameter int              ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]      HALT_OP  = 4'hF
) (
  input  logic                clk,
  input  logic                rst_n,
  mips_lite_mc_ctrl_if.master bus,
  input  logic                start_i,
  output logic [15:0]         instruc_o,
  input  logic                Reg_write_dec_i,
  input  logic                Mem_write_dec_i,
  input  logic                Reg_src_dec_i,
  output logic                ALU_res_en_o,
  output logic                Reg_write_o,
  output logic                busy_o,
  output logic                halted_o,
  output logic [15:0]         instr_count_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       cnt_inc;
  logic              imem_req_q, dmem_req_q, alu_en_q, wb_q, busy_q, halted_q;

  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start_i) begin
          state_d = S_FETCH;
          pc_d    = RESET_PC;
          cnt_d   = '0;
        end
      end
      S_FETCH: begin
        if (bus.imem_ready) begin
          ir_d    = bus.imem_rdata;
          pc_d    = pc_q + 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = (ir_q[15:12] == HALT_OP) ? S_HALT : S_EXEC;
      S_EXEC:   state_d = (Mem_write_dec_i | Reg_src_dec_i) ? S_MEM : S_WB;
      S_MEM: begin
        if (bus.dmem_ready) begin
          // A store retires here; a load still has its register writeback ahead.
          if (Reg_src_dec_i) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            cnt_d   = cnt_inc;
          end
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        cnt_d   = cnt_inc;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output flags are decoded from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      cnt_q      <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      alu_en_q   <= 1'b0;
      wb_q       <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      cnt_q      <= cnt_d;
      imem_req_q <= (state_d == S_FETCH);
      dmem_req_q <= (state_d == S_MEM);
      alu_en_q   <= (state_d == S_EXEC);
      wb_q       <= (state_d == S_WB);
      busy_q     <= (state_d != S_IDLE) && (state_d != S_HALT);
      halted_q   <= (state_d == S_HALT);
    end
  end

  assign bus.imem_req   = imem_req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.dmem_req   = dmem_req_q;
  // Decoder enables only reach the datapath inside their own state.
  assign bus.dmem_we    = dmem_req_q & Mem_write_dec_i;
  assign Reg_write_o    = wb_q & Reg_write_dec_i;
  assign instruc_o      = ir_q;
  assign ALU_res_en_o   = alu_en_q;
  assign busy_o         = busy_q;
  assign halted_o       = halted_q;
  assign instr_count_o  = cnt_q;

endmodule

// File: tb/tb_mips_lite_mc_ctrl.sv
// Scoreboard bench: each fetched instruction queues its expected retirement, which is
// popped and checked when instr_count advances.
module tb_mips_lite_mc_ctrl;
  localparam int ADDR_W = 8;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [15:0] instruc, instr_count;
  logic        rw_dec, mw_dec, rs_dec;
  logic        alu_en, reg_write, busy, halted;

  mips_lite_mc_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  mips_lite_mc_ctrl #(.ADDR_W(ADDR_W), .RESET_PC(8'h00), .HALT_OP(4'hF)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .start_i(start), .instruc_o(instruc),
    .Reg_write_dec_i(rw_dec), .Mem_write_dec_i(mw_dec), .Reg_src_dec_i(rs_dec),
    .ALU_res_en_o(alu_en), .Reg_write_o(reg_write), .busy_o(busy), .halted_o(halted),
    .instr_count_o(instr_count)
  );

  always #5 clk = ~clk;

  // Decoder stand-in: op 8 = load, op 9 = store (Reg_write also set), op 7 = no writeback.
  assign rs_dec = (instruc[15:12] == 4'h8);
  assign mw_dec = (instruc[15:12] == 4'h9);
  assign rw_dec = (instruc[15:12] != 4'h7);

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  logic [15:0] imem [256];
  int imem_wait = 0, dmem_wait = 0;
  int icnt_w = 0, dcnt_w = 0;

  // Memory responders: ready after N full request cycles (N=0 is zero-wait).
  always @(posedge clk) begin
    #2;
    bus.imem_rdata = imem[bus.imem_addr];
    if (bus.imem_req) begin
      bus.imem_ready = (icnt_w >= imem_wait);
      icnt_w++;
    end else begin
      bus.imem_ready = 1'b0;
      icnt_w = 0;
    end
    if (bus.dmem_req) begin
      bus.dmem_ready = (dcnt_w >= dmem_wait);
      dcnt_w++;
    end else begin
      bus.dmem_ready = 1'b0;
      dcnt_w = 0;
    end
  end

  typedef struct {
    logic [15:0] instr;
    int cnt, lat, rw, we;
  } exp_t;
  exp_t sb[$];

  int cyc = 0, rw_n = 0, we_n = 0, alu_n = 0, exp_cnt = 0, rw_total = 0;
  logic prev_req = 1'b0, prev_busy = 1'b0;
  logic [15:0] prev_cnt = '0;

  always @(negedge clk) begin
    exp_t e;
    logic [3:0] op;
    if (!rst_n) begin
      sb.delete();
      exp_cnt = 0;
    end
    if (busy && !prev_busy) exp_cnt = 0;
    if (rst_n && instr_count == prev_cnt + 16'd1) begin
      if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("ret_instr", instruc, e.instr);
        chk("ret_count", instr_count, e.cnt);
        chk("ret_latency", cyc, e.lat);
        chk("ret_regwrite", rw_n, e.rw);
        chk("ret_dmem_we", we_n, e.we);
        chk("ret_alu_en", alu_n, 1);
      end
    end
    if (bus.dmem_we) chk("we_gate", bus.dmem_req, 1'b1);
    if (reg_write) begin rw_n++; rw_total++; end
    if (bus.dmem_we) we_n++;
    if (alu_en) alu_n++;
    if (bus.imem_req && !prev_req) cyc = 1;
    else if (busy) cyc++;
    if (bus.imem_req && bus.imem_ready) begin
      op = bus.imem_rdata[15:12];
      if (op != 4'hF) begin
        exp_cnt++;
        e.instr = bus.imem_rdata;
        e.cnt   = exp_cnt;
        e.lat   = 4 + imem_wait + ((op == 4'h8) ? 1 + dmem_wait : (op == 4'h9) ? dmem_wait : 0);
        e.rw    = (op == 4'h9 || op == 4'h7) ? 0 : 1;
        e.we    = (op == 4'h9) ? dmem_wait + 1 : 0;
        sb.push_back(e);
      end
      rw_n = 0; we_n = 0; alu_n = 0;
    end
    prev_req  = bus.imem_req;
    prev_busy = busy;
    prev_cnt  = instr_count;
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("start_busy", busy, 1'b1);
    chk("start_pc", bus.imem_addr, 8'h00);
    chk("start_count", instr_count, 16'd0);
  endtask

  task automatic wait_halt(input int bound);
    int n = 0;
    while (!halted && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("halt_reached", halted, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, rw_before;
    for (int i = 0; i < 256; i++) imem[i] = 16'h1000;
    rst_n = 1'b0; start = 1'b0;
    bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0; bus.imem_rdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_halted", halted, 1'b0);
    chk("idle_imem_req", bus.imem_req, 1'b0);
    chk("idle_dmem_req", bus.dmem_req, 1'b0);
    chk("idle_alu_en", alu_en, 1'b0);
    chk("idle_regwrite", reg_write, 1'b0);
    chk("idle_addr", bus.imem_addr, 8'h00);
    chk("idle_count", instr_count, 16'd0);
    chk("idle_instruc", instruc, 16'h0000);

    // Three ALU ops then halt, zero-wait memories.
    imem[0] = 16'h0000; imem[1] = 16'h1234; imem[2] = 16'h2345; imem[3] = 16'hF000;
    pulse_start();
    wait_halt(200);
    chk("halt_busy", busy, 1'b0);
    chk("halt_count", instr_count, 16'd3);
    chk("halt_addr", bus.imem_addr, 8'h04);
    chk("halt_sb_empty", sb.size(), 0);

    // Load, store, non-writing ALU op with waited memories; restart from HALT.
    imem_wait = 1; dmem_wait = 2;
    imem[0] = 16'h8123; imem[1] = 16'h9456; imem[2] = 16'h7001; imem[3] = 16'hF000;
    pulse_start();
    wait_halt(200);
    chk("halt2_count", instr_count, 16'd3);
    chk("halt2_sb_empty", sb.size(), 0);

    // PC wrap at 8'hFF, then reset while a load waits in MEM.
    imem_wait = 0; dmem_wait = 0;
    for (int i = 0; i < 256; i++) imem[i] = 16'h1000;
    pulse_start();
    n = 0;
    while (!(bus.imem_req && bus.imem_ready && bus.imem_addr == 8'hFF) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_pc_ff", bus.imem_addr, 8'hFF);
    imem[0] = 16'h8000;
    dmem_wait = 50;
    @(negedge clk);
    chk("pc_wrap", bus.imem_addr, 8'h00);
    n = 0;
    while (!bus.dmem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mem_reached", bus.dmem_req, 1'b1);
    rw_before = rw_total;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_dmem_req", bus.dmem_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", instr_count, 16'd0);
    chk("rst_addr", bus.imem_addr, 8'h00);
    chk("rst_instruc", instruc, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_no_regwrite", rw_total, rw_before);
    chk("rst_stays_idle", busy, 1'b0);
    chk("rst_not_halted", halted, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
